// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - shared types and constants for the RAM stream reader
//
// Contents:
//   state_t    : burst FSM states (IDLE / ISSUE / DRAIN)
//   SKID_DEPTH : entries in the skid FIFO, also the cap on reads outstanding or buffered

package ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 3;

endpackage

// File: rtl/ram_reader_skid_fifo.sv
// rtl/ram_reader_skid_fifo.sv - depth-3 register FIFO of {last, data} absorbing RAM read latency
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   push, push_data/last : write one entry (never presented while full)
//   pop                  : remove the head entry (ignored while empty)
//   count                : current occupancy, 0..3
//   head_data/last       : head entry, forced to zero while empty

module ram_reader_skid_fifo
   import ram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [1:0]            count,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last
);

   logic [DATA_WIDTH:0] mem [SKID_DEPTH];
   logic [1:0]          wr_ptr;
   logic [1:0]          rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'(SKID_DEPTH)) || do_pop);

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= {push_last, push_data};
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Gate the head so an empty FIFO presents zeros rather than a stale entry.
   assign head_data = (count != 2'd0) ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
   assign head_last = (count != 2'd0) ? mem[rd_ptr][DATA_WIDTH]     : 1'b0;

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader turning sequential RAM reads into a valid/ready stream
//
// Ports:
//   clk, rst                         : clock (also RAM read side), asynchronous active-high reset
//   start_valid/ready, addr, len     : burst command handshake; len 0 completes with no reads
//   rd_en, rd_addr, rd_data          : RAM read port, data returned one cycle after rd_en
//   out_valid/ready, data, last      : output stream, last marks the final word of a burst
//   busy                             : burst in progress (including a pending zero-length done)
//   done                             : one-cycle completion pulse

module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  start_len,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  remain_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  done_q;
   logic                  zero_pend_q;

   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_last;

   logic [2:0]            credit;
   logic                  credit_ok;
   logic                  start_hs;
   logic                  start_zero;
   logic                  final_issue;
   logic                  pop;
   logic                  last_pop;

   // Credit uses registered occupancy only, so out_ready never reaches rd_en combinationally;
   // a pop frees credit for the following cycle.
   assign credit      = {1'b0, fifo_count} + {2'b00, inflight_q};
   assign credit_ok   = credit < 3'(SKID_DEPTH);
   assign start_hs    = start_valid && start_ready;
   assign start_zero  = start_hs && (start_len == '0);
   assign final_issue = rd_en && (remain_q == LEN_WIDTH'(1));
   assign pop         = out_valid && out_ready;
   assign last_pop    = pop && fifo_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_hs && (start_len != '0)) state_d = ISSUE;
         ISSUE:   if (final_issue)                   state_d = DRAIN;
         DRAIN:   if (last_pop)                      state_d = IDLE;
         default:                                    state_d = IDLE;
      endcase
   end

   always_comb begin
      start_ready = 1'b0;
      rd_en       = 1'b0;
      busy        = zero_pend_q;
      case (state_q)
         IDLE:    start_ready = 1'b1;
         ISSUE: begin
            rd_en = credit_ok;
            busy  = 1'b1;
         end
         DRAIN:   busy = 1'b1;
         default: busy = zero_pend_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q          <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
         zero_pend_q     <= 1'b0;
      end else begin
         inflight_q      <= rd_en;
         inflight_last_q <= final_issue;
         done_q          <= start_zero || ((state_q == DRAIN) && last_pop);
         zero_pend_q     <= start_zero;
         if (start_hs) begin
            addr_q   <= start_addr;
            remain_q <= start_len;
         end else if (rd_en) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            remain_q <= remain_q - LEN_WIDTH'(1);
         end
      end
   end

   ram_reader_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (rd_data),
      .push_last (inflight_last_q),
      .pop       (pop),
      .count     (fifo_count),
      .head_data (fifo_data),
      .head_last (fifo_last)
   );

   assign rd_addr   = addr_q;
   assign out_valid = fifo_count != 2'd0;
   assign out_data  = fifo_data;
   assign out_last  = fifo_last;
   assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed self-checking bench for ram_stream_reader with a RAM model

module tb_ram_stream_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [8:0]  start_addr = '0;
   logic [9:0]  start_len = '0;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] mem [0:511];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;

   logic [31:0] got_data [$];
   logic        got_last [$];
   int first_valid_k, last_k, done_k, done_cnt;
   int issued, accepted, max_out, stab_viol, ready_seen;

   ram_stream_reader #(
      .ADDR_WIDTH (9),
      .DATA_WIDTH (32),
      .LEN_WIDTH  (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .start_addr  (start_addr),
      .start_len   (start_len),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs from the cycle after a start handshake (k=1) until done is seen or the budget ends.
   task automatic collect(input int budget, input logic [3:0] pat);
      int k;
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      got_data.delete();
      got_last.delete();
      first_valid_k = -1; last_k = -1; done_k = -1; done_cnt = 0;
      issued = 0; accepted = 0; max_out = 0; stab_viol = 0; ready_seen = 0;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      for (int i = 0; i < budget; i++) begin
         k = cyc - t0 + 1;
         out_ready = pat[k % 4];
         if (prev_stall && !(out_valid && out_data === prev_data && out_last === prev_last))
            stab_viol++;
         if (out_valid && first_valid_k < 0) first_valid_k = k;
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            if (out_last) last_k = k;
            accepted++;
         end
         if (rd_en) issued++;
         if (issued - accepted > max_out) max_out = issued - accepted;
         if (start_ready && !done) ready_seen++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (done) begin
            done_cnt++;
            done_k = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_burst(input string tag, input int base, input int n);
      check({tag, "_count"}, got_data.size(), n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_data"}, (i < got_data.size()) ? got_data[i] : 32'hxxxxxxxx,
               32'(((base + i) % 512) + 32'h100));
         check({tag, "_last"}, (i < got_last.size()) ? got_last[i] : 1'bx, (i == n - 1));
      end
   endtask

   task automatic start_burst(input int addr, input int len);
      start_addr  = 9'(addr);
      start_len   = 10'(len);
      start_valid = 1'b1;
      @(negedge clk);
      t0 = cyc;
      start_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'(i + 32'h100);

      // Reset values
      @(negedge clk);
      check("rst_start_ready", start_ready, 1);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);

      // addr 4, len 8, out_ready held high
      out_ready = 1'b1;
      start_burst(4, 8);
      check("b1_rd_en_t1", rd_en, 1);
      check("b1_rd_addr_t1", rd_addr, 4);
      check("b1_busy", busy, 1);
      check("b1_start_ready", start_ready, 0);
      collect(40, 4'b1111);
      check_burst("b1", 4, 8);
      check("b1_first_valid_cycle", first_valid_k, 3);
      check("b1_last_cycle", last_k, 10);
      check("b1_done_cycle", done_k, 11);
      check("b1_start_ready_at_done", start_ready, 1);
      @(negedge clk);
      check("b1_done_one_pulse", done, 0);
      check("b1_busy_after", busy, 0);

      // same burst with out_ready pattern 1,0,0,1
      start_burst(4, 8);
      collect(100, 4'b1001);
      check_burst("b2", 4, 8);
      check("b2_done_seen", done_cnt, 1);
      check("b2_outstanding_le3", max_out <= 3, 1);
      check("b2_stream_stable", stab_viol, 0);
      out_ready = 1'b1;
      @(negedge clk);

      // address wrap 510, 511, 0, 1
      start_burst(510, 4);
      collect(40, 4'b1111);
      check_burst("wrap", 510, 4);
      check("wrap_done_cycle", done_k, 7);
      @(negedge clk);

      // zero-length burst
      start_burst(33, 0);
      check("len0_done", done, 1);
      check("len0_busy", busy, 1);
      check("len0_rd_en", rd_en, 0);
      check("len0_out_valid", out_valid, 0);
      @(negedge clk);
      check("len0_done_clear", done, 0);
      check("len0_busy_clear", busy, 0);
      check("len0_rd_en_after", rd_en, 0);

      // start_valid held through a burst: next command accepted on the done cycle
      start_addr  = 9'd20;
      start_len   = 10'd3;
      start_valid = 1'b1;
      @(negedge clk);
      t0 = cyc;
      start_addr = 9'd40;
      start_len  = 10'd2;
      check("b2b_ready_low", start_ready, 0);
      collect(40, 4'b1111);
      check_burst("b2b_a", 20, 3);
      check("b2b_no_early_ready", ready_seen, 0);
      check("b2b_ready_at_done", start_ready, 1);
      @(negedge clk);
      t0 = cyc;
      start_valid = 1'b0;
      check("b2b_second_rd_en", rd_en, 1);
      check("b2b_second_addr", rd_addr, 40);
      collect(40, 4'b1111);
      check_burst("b2b_b", 40, 2);
      @(negedge clk);

      // reset mid-burst with two words buffered
      out_ready = 1'b0;
      start_burst(100, 8);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("mid_out_valid", out_valid, 1);
      check("mid_credit_stall", rd_en, 0);
      check("mid_head", out_data, 32'h164);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      check("arst_rd_en", rd_en, 0);
      check("arst_rd_addr", rd_addr, 0);
      check("arst_busy", busy, 0);
      check("arst_start_ready", start_ready, 1);
      @(negedge clk);
      check("arst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      start_burst(7, 3);
      collect(40, 4'b1111);
      check_burst("post_rst", 7, 3);
      check("post_rst_first_valid", first_valid_k, 3);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
